debug_cmd_queue: RTL and testbench

//  Single-clock, parametrised request/response queue between a debug transport (JTAG/UART

---
 rtl/debug_cmd_queue.sv | 268 ++++++++++++++++++++++++++
 tb/tb_debug_cmd_queue.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_cmd_queue.sv
// ---------------------------------------------------------------------------
// debug_cmd_queue
//
// Single-clock request/response queue between a debug transport (deframed
// JTAG/UART commands, already in the system clock domain) and the HASTI
// debug master.
//
// Behaviour:
//   - Transport requests are buffered in a request FIFO.
//   - Responses are buffered in a response FIFO.
//   - Requests are issued to the target only while both of these hold:
//       * the in-flight count is below MAX_OUTSTANDING, and
//       * the in-flight count plus the buffered responses is below
//         RESP_DEPTH.
//     This credit rule means every answer already has a slot waiting for it.
//
// Optional feature (compile-time macro DEBUG_CMD_QUEUE_TIMEOUT_EN):
//   - A watchdog retires a hung request after TIMEOUT cycles without a
//     target response.
//   - The retired request is answered to the transport with a synthetic
//     NACK (ack=0, data=all ones).
//   - The target's late answer for that request is later discarded.
//   - A sticky timeout_err flag records that this happened.
//   Without the macro:
//   - there is no timer,
//   - timeout_err is tied low, and
//   - clr_err is ignored.
//
// Parameters:
//   CMD_W, DATA_W            command / data field widths
//   REQ_DEPTH, RESP_DEPTH    FIFO depths (powers of two, >= 2)
//   MAX_OUTSTANDING          requests in flight at the target, 1..RESP_DEPTH
//   TIMEOUT                  watchdog period in cycles (>= 2)
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   tp_req_*                 transport -> queue request (valid/ready/cmd/data)
//   tp_resp_*                queue -> transport response (valid/ready/ack/data)
//   io_req_*                 queue -> target request (valid/ready/cmd/data)
//   io_resp_*                target -> queue response (valid/ready/ack/data)
//   outstanding              requests issued and not yet answered
//   timeout_err              sticky timeout indication
//   clr_err                  clears timeout_err (a new timeout wins)
// ---------------------------------------------------------------------------
module debug_cmd_queue #(
  parameter int CMD_W           = 2,
  parameter int DATA_W          = 32,
  parameter int REQ_DEPTH       = 4,
  parameter int RESP_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int TIMEOUT         = 1024
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic                                 tp_req_valid,
  output logic                                 tp_req_ready,
  input  logic [CMD_W-1:0]                     tp_req_bits_cmd,
  input  logic [DATA_W-1:0]                    tp_req_bits_data,
  output logic                                 tp_resp_valid,
  input  logic                                 tp_resp_ready,
  output logic                                 tp_resp_bits_ack,
  output logic [DATA_W-1:0]                    tp_resp_bits_data,
  output logic                                 io_req_valid,
  input  logic                                 io_req_ready,
  output logic [CMD_W-1:0]                     io_req_bits_cmd,
  output logic [DATA_W-1:0]                    io_req_bits_data,
  input  logic                                 io_resp_valid,
  output logic                                 io_resp_ready,
  input  logic                                 io_resp_bits_ack,
  input  logic [DATA_W-1:0]                    io_resp_bits_data,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                 timeout_err,
  input  logic                                 clr_err
);

  localparam int REQ_AW  = $clog2(REQ_DEPTH);
  localparam int RESP_AW = $clog2(RESP_DEPTH);
  localparam int OUT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam int SUM_W   = $clog2(MAX_OUTSTANDING + RESP_DEPTH + 1);
  localparam int REQ_W   = CMD_W + DATA_W;
  localparam int RESP_W  = 1 + DATA_W;

  // -------------------------------------------------------------------------
  // Request FIFO
  // -------------------------------------------------------------------------
  logic [REQ_W-1:0]  req_mem [REQ_DEPTH];
  logic [REQ_AW:0]   req_wptr;
  logic [REQ_AW:0]   req_rptr;
  logic              req_empty;
  logic              req_full;
  logic              tp_req_fire;
  logic              io_req_fire;

  // The pointers carry one extra wrap bit, so that a full FIFO and an empty
  // FIFO can be told apart with equal index bits.
  assign req_empty    = (req_wptr == req_rptr);
  assign req_full     = (req_wptr[REQ_AW] != req_rptr[REQ_AW]) &&
                        (req_wptr[REQ_AW-1:0] == req_rptr[REQ_AW-1:0]);
  assign tp_req_ready = !req_full;
  assign tp_req_fire  = tp_req_valid && tp_req_ready;
  assign io_req_fire  = io_req_valid && io_req_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_wptr <= '0;
      req_rptr <= '0;
    end else begin
      if (tp_req_fire) req_wptr <= req_wptr + (REQ_AW+1)'(1);
      if (io_req_fire) req_rptr <= req_rptr + (REQ_AW+1)'(1);
    end
  end

  // The storage is not reset. Nothing reads an entry until it has been
  // written.
  always_ff @(posedge clk) begin
    if (tp_req_fire) req_mem[req_wptr[REQ_AW-1:0]] <= {tp_req_bits_cmd, tp_req_bits_data};
  end

  assign {io_req_bits_cmd, io_req_bits_data} = req_mem[req_rptr[REQ_AW-1:0]];

  // -------------------------------------------------------------------------
  // Response FIFO
  // -------------------------------------------------------------------------
  logic [RESP_W-1:0] resp_mem [RESP_DEPTH];
  logic [RESP_AW:0]  resp_wptr;
  logic [RESP_AW:0]  resp_rptr;
  logic [RESP_AW:0]  resp_count;
  logic              resp_empty;
  logic              resp_full;
  logic              resp_enq;
  logic [RESP_W-1:0] resp_enq_data;
  logic              tp_resp_fire;
  logic              io_resp_fire;
  logic              dropping;
  logic              expire;
  logic              retire;

  assign resp_count    = resp_wptr - resp_rptr;
  assign resp_empty    = (resp_wptr == resp_rptr);
  assign resp_full     = (resp_wptr[RESP_AW] != resp_rptr[RESP_AW]) &&
                         (resp_wptr[RESP_AW-1:0] == resp_rptr[RESP_AW-1:0]);
  assign tp_resp_valid = !resp_empty;
  assign tp_resp_fire  = tp_resp_valid && tp_resp_ready;
  assign io_resp_fire  = io_resp_valid && io_resp_ready;

  // A request retires in one of two ways:
  //   - a real answer arrives that is not owed to an earlier timeout, or
  //   - the watchdog expires.
  // Expiry only happens in a cycle with no target response. The two sources
  // are therefore never active together, and at most one entry is enqueued
  // per cycle.
  assign retire        = (io_resp_fire && !dropping) || expire;
  assign resp_enq      = retire;
  assign resp_enq_data = expire ? {1'b0, {DATA_W{1'b1}}}
                                : {io_resp_bits_ack, io_resp_bits_data};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_wptr <= '0;
      resp_rptr <= '0;
    end else begin
      if (resp_enq)     resp_wptr <= resp_wptr + (RESP_AW+1)'(1);
      if (tp_resp_fire) resp_rptr <= resp_rptr + (RESP_AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (resp_enq) resp_mem[resp_wptr[RESP_AW-1:0]] <= resp_enq_data;
  end

  assign {tp_resp_bits_ack, tp_resp_bits_data} = resp_mem[resp_rptr[RESP_AW-1:0]];

  // -------------------------------------------------------------------------
  // Issue credit
  // -------------------------------------------------------------------------
  // A request may be issued only if its answer is guaranteed a response
  // slot. Every request in flight and every buffered response counts
  // against the response FIFO depth.
  logic [SUM_W-1:0] committed;

  assign committed    = SUM_W'(outstanding) + SUM_W'(resp_count);
  assign io_req_valid = !req_empty &&
                        (outstanding < OUT_W'(MAX_OUTSTANDING)) &&
                        (committed < SUM_W'(RESP_DEPTH));

  // In-flight count: an issue and a retirement in the same cycle cancel out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outstanding <= '0;
    end else if (io_req_fire && !retire) begin
      outstanding <= outstanding + OUT_W'(1);
    end else if (!io_req_fire && retire) begin
      outstanding <= outstanding - OUT_W'(1);
    end
  end

`ifdef DEBUG_CMD_QUEUE_TIMEOUT_EN
  // -------------------------------------------------------------------------
  // Watchdog
  // -------------------------------------------------------------------------
  localparam int TMR_W = $clog2(TIMEOUT);

  logic [TMR_W-1:0] timer;
  logic [OUT_W-1:0] drop_cnt;

  // While answers owed to timed-out requests are still pending, the next
  // target responses belong to those requests. They are accepted
  // unconditionally and discarded.
  assign dropping      = (drop_cnt != '0);
  assign io_resp_ready = dropping || !resp_full;
  assign expire        = (outstanding != '0) && !io_resp_fire &&
                         (timer == TMR_W'(TIMEOUT - 1));

  // The timer measures how long the target has been silent with work
  // pending. Any target response restarts it, including one that is
  // discarded.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer <= '0;
    end else if ((outstanding == '0) || io_resp_fire || expire) begin
      timer <= '0;
    end else begin
      timer <= timer + TMR_W'(1);
    end
  end

  // Count of target answers still owed for requests that have already been
  // NACKed. Expiry requires a cycle with no response, so an increment and a
  // decrement never happen together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= '0;
    end else if (expire) begin
      if (drop_cnt != OUT_W'(MAX_OUTSTANDING)) drop_cnt <= drop_cnt + OUT_W'(1);
    end else if (io_resp_fire && dropping) begin
      drop_cnt <= drop_cnt - OUT_W'(1);
    end
  end

  // Sticky error flag. A new timeout takes priority over a clear request in
  // the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_err <= 1'b0;
    end else if (expire) begin
      timeout_err <= 1'b1;
    end else if (clr_err) begin
      timeout_err <= 1'b0;
    end
  end
`else
  // Without the watchdog, every target response is a real answer.
  logic unused_cfg;

  assign dropping      = 1'b0;
  assign expire        = 1'b0;
  assign io_resp_ready = !resp_full;
  assign timeout_err   = 1'b0;
  assign unused_cfg    = clr_err | (TIMEOUT < 2);
`endif

  // The credit rule reserves a slot for every answer the target can
  // legally send. A real response arriving at a full FIFO therefore means
  // the target answered something that was never issued.
  resp_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
                                     !(io_resp_valid && !dropping && resp_full));

endmodule

// File: tb/tb_debug_cmd_queue.sv
// ---------------------------------------------------------------------------
// tb_debug_cmd_queue
//
// Drives debug_cmd_queue with transport, target and sink behaviour models,
// and compares every cycle against a transaction-level reference:
//   - queues of requests and expected responses, and
//   - counts of requests in flight and answers owed to timed-out requests.
// Watchdog scenarios are included when DEBUG_CMD_QUEUE_TIMEOUT_EN is
// defined.
// ---------------------------------------------------------------------------
module tb_debug_cmd_queue;

  localparam int CMD_W      = 2;
  localparam int DATA_W     = 32;
  localparam int REQ_DEPTH  = 4;
  localparam int RESP_DEPTH = 4;
  localparam int MAX_OUT    = 2;
  localparam int TIMEOUT    = 16;
  localparam int OW         = $clog2(MAX_OUT + 1);
`ifdef DEBUG_CMD_QUEUE_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [DATA_W-1:0] data;
  } req_t;

  typedef struct packed {
    logic              ack;
    logic [DATA_W-1:0] data;
  } resp_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              tp_req_valid = 1'b0;
  logic              tp_req_ready;
  logic [CMD_W-1:0]  tp_req_bits_cmd = '0;
  logic [DATA_W-1:0] tp_req_bits_data = '0;
  logic              tp_resp_valid;
  logic              tp_resp_ready = 1'b0;
  logic              tp_resp_bits_ack;
  logic [DATA_W-1:0] tp_resp_bits_data;
  logic              io_req_valid;
  logic              io_req_ready = 1'b1;
  logic [CMD_W-1:0]  io_req_bits_cmd;
  logic [DATA_W-1:0] io_req_bits_data;
  logic              io_resp_valid = 1'b0;
  logic              io_resp_ready;
  logic              io_resp_bits_ack = 1'b0;
  logic [DATA_W-1:0] io_resp_bits_data = '0;
  logic [OW-1:0]     outstanding;
  logic              timeout_err;
  logic              clr_err = 1'b0;

  debug_cmd_queue #(
    .CMD_W(CMD_W), .DATA_W(DATA_W), .REQ_DEPTH(REQ_DEPTH), .RESP_DEPTH(RESP_DEPTH),
    .MAX_OUTSTANDING(MAX_OUT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .tp_req_valid(tp_req_valid), .tp_req_ready(tp_req_ready),
    .tp_req_bits_cmd(tp_req_bits_cmd), .tp_req_bits_data(tp_req_bits_data),
    .tp_resp_valid(tp_resp_valid), .tp_resp_ready(tp_resp_ready),
    .tp_resp_bits_ack(tp_resp_bits_ack), .tp_resp_bits_data(tp_resp_bits_data),
    .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
    .io_req_bits_cmd(io_req_bits_cmd), .io_req_bits_data(io_req_bits_data),
    .io_resp_valid(io_resp_valid), .io_resp_ready(io_resp_ready),
    .io_resp_bits_ack(io_resp_bits_ack), .io_resp_bits_data(io_resp_bits_data),
    .outstanding(outstanding), .timeout_err(timeout_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference state, kept in transaction terms
  req_t  src_q[$];   // requests the transport still has to offer
  req_t  req_q[$];   // accepted by the queue, not yet issued
  req_t  tgt_q[$];   // held by the target, answer not yet sent
  resp_t resp_q[$];  // responses the transport must see, in order
  int    inflight = 0;
  int    drop = 0;
  int    timer = 0;
  logic  err_model = 1'b0;
  int    io_req_fires = 0;
  int    tp_resp_fires = 0;

  // Agent knobs
  bit tgt_en = 0, tgt_rand = 0, tgt_rand_ready = 0;
  bit src_rand = 0, sink_en = 0, sink_rand = 0;
  int tgt_delay = 0;

  task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pushReqs(input int n);
    req_t r;
    for (int i = 0; i < n; i++) begin
      r.cmd  = CMD_W'($urandom_range(0, (1 << CMD_W) - 1));
      r.data = $urandom;
      src_q.push_back(r);
    end
  endtask

  task automatic applyStimulus();
    if (!tp_req_valid && src_q.size() > 0 && (!src_rand || $urandom_range(0, 2) != 0)) begin
      tp_req_valid = 1'b1;
      {tp_req_bits_cmd, tp_req_bits_data} = src_q[0];
    end
    io_req_ready = !tgt_rand_ready || ($urandom_range(0, 3) != 0);
    if (tgt_en && !io_resp_valid && tgt_q.size() > 0) begin
      if (tgt_delay > 0) tgt_delay--;
      else begin
        io_resp_valid     = 1'b1;
        io_resp_bits_ack  = 1'($urandom_range(0, 1));
        io_resp_bits_data = $urandom;
      end
    end
    tp_resp_ready = sink_en && (!sink_rand || $urandom_range(0, 1) == 1);
  endtask

  task automatic checkOutput();
    req_t  rh;
    resp_t ph;
    compare("tp_req_ready", tp_req_ready, req_q.size() < REQ_DEPTH);
    compare("io_req_valid", io_req_valid,
            req_q.size() > 0 && inflight < MAX_OUT && inflight + resp_q.size() < RESP_DEPTH);
    if (io_req_valid && req_q.size() > 0) begin
      rh = req_q[0];
      compare("io_req_bits", {io_req_bits_cmd, io_req_bits_data}, rh);
    end
    compare("tp_resp_valid", tp_resp_valid, resp_q.size() > 0);
    if (tp_resp_valid && resp_q.size() > 0) begin
      ph = resp_q[0];
      compare("tp_resp_bits", {tp_resp_bits_ack, tp_resp_bits_data}, ph);
    end
    compare("io_resp_ready", io_resp_ready, drop > 0 || resp_q.size() < RESP_DEPTH);
    compare("outstanding", outstanding, inflight);
    compare("timeout_err", timeout_err, err_model);
  endtask

  // One clock: drive at the falling edge, check just after, then replay the
  // handshakes that fire at the rising edge into the reference.
  task automatic stepCycle();
    logic  f_treq, f_ireq, f_iresp, f_tresp, f_clr, expire;
    int    tnext;
    req_t  r;
    resp_t p;
    applyStimulus();
    #1;
    checkOutput();
    f_treq  = tp_req_valid && tp_req_ready;
    f_ireq  = io_req_valid && io_req_ready;
    f_iresp = io_resp_valid && io_resp_ready;
    f_tresp = tp_resp_valid && tp_resp_ready;
    f_clr   = clr_err;
    expire  = TO_EN && inflight > 0 && !f_iresp && timer == TIMEOUT - 1;
    tnext   = (inflight == 0 || f_iresp || expire) ? 0 : timer + 1;
    @(posedge clk);
    @(negedge clk);
    if (f_treq) begin
      r = src_q.pop_front();
      req_q.push_back(r);
      tp_req_valid = 1'b0;
    end
    if (f_ireq) begin
      r = req_q.pop_front();
      tgt_q.push_back(r);
      inflight++;
      io_req_fires++;
    end
    if (f_iresp) begin
      r = tgt_q.pop_front();
      if (drop > 0) drop--;
      else begin
        p.ack  = io_resp_bits_ack;
        p.data = io_resp_bits_data;
        resp_q.push_back(p);
        inflight--;
      end
      io_resp_valid = 1'b0;
      tgt_delay = tgt_rand ? $urandom_range(0, 3) : 0;
    end else if (expire) begin
      p.ack  = 1'b0;
      p.data = '1;
      resp_q.push_back(p);
      inflight--;
      if (drop < MAX_OUT) drop++;
    end
    if (f_tresp) begin
      p = resp_q.pop_front();
      tp_resp_fires++;
    end
    if (expire) err_model = 1'b1;
    else if (f_clr) err_model = 1'b0;
    timer = tnext;
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((src_q.size() + req_q.size() + tgt_q.size() + resp_q.size() + inflight) != 0
           && n < limit) begin
      stepCycle();
      n++;
    end
    compare("drain_done", src_q.size() + req_q.size() + tgt_q.size() + resp_q.size() + inflight, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int base2;

    // Asynchronous reset from power-up, checked before any clock edge
    #1 reset_n = 1'b0;
    #1;
    compare("rst_io_req_valid", io_req_valid, 0);
    compare("rst_tp_resp_valid", tp_resp_valid, 0);
    compare("rst_outstanding", outstanding, 0);
    compare("rst_timeout_err", timeout_err, 0);
    compare("rst_tp_req_ready", tp_req_ready, 1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Throughput: 8 back-to-back requests with a prompt target and sink
    tgt_en = 1; sink_en = 1;
    base = tp_resp_fires;
    pushReqs(8);
    drain(200);
    compare("tput_delivered", tp_resp_fires - base, 8);

    // Credit: target silent and sink stalled, so only MAX_OUT requests issue
    tgt_en = 0; sink_en = 0;
    base = io_req_fires;
    pushReqs(4);
    repeat (10) stepCycle();
    compare("credit_fires", io_req_fires - base, MAX_OUT);
    compare("credit_outstanding", outstanding, MAX_OUT);
    compare("credit_io_req_valid", io_req_valid, 0);
    tgt_en = 1; sink_en = 1;
    drain(200);

    // Backpressure: sink stalled, the response FIFO fills, the 5th request waits
    tgt_en = 1; sink_en = 0;
    base = io_req_fires;
    base2 = tp_resp_fires;
    pushReqs(5);
    repeat (20) stepCycle();
    compare("bp_issued", io_req_fires - base, RESP_DEPTH);
    compare("bp_io_req_valid", io_req_valid, 0);
    compare("bp_tp_resp_valid", tp_resp_valid, 1);
    compare("bp_io_resp_ready", io_resp_ready, 0);
    sink_en = 1;
    drain(200);
    compare("bp_delivered", tp_resp_fires - base2, 5);

    // Randomised traffic on every handshake
    tgt_rand = 1; tgt_rand_ready = 1; src_rand = 1; sink_rand = 1;
    pushReqs(40);
    repeat (150) stepCycle();
    tgt_rand = 0; tgt_rand_ready = 0; src_rand = 0; sink_rand = 0;
    tgt_delay = 0;
    drain(400);

    // Reset asserted mid-traffic: outputs clear without a clock edge
    tgt_en = 1; sink_en = 0;
    pushReqs(5);
    repeat (8) stepCycle();
    compare("pre_rst_busy", tp_resp_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    compare("mid_rst_io_req_valid", io_req_valid, 0);
    compare("mid_rst_tp_resp_valid", tp_resp_valid, 0);
    compare("mid_rst_outstanding", outstanding, 0);
    compare("mid_rst_timeout_err", timeout_err, 0);
    tp_req_valid = 1'b0; io_resp_valid = 1'b0; clr_err = 1'b0;
    src_q.delete(); req_q.delete(); tgt_q.delete(); resp_q.delete();
    inflight = 0; drop = 0; timer = 0; err_model = 1'b0; tgt_delay = 0;
    @(negedge clk);
    reset_n = 1'b1;
    sink_en = 1;
    pushReqs(3);
    drain(200);

`ifdef DEBUG_CMD_QUEUE_TIMEOUT_EN
    // Timeout: a silent target gets a synthetic NACK on the 16th cycle
    tgt_en = 0; sink_en = 0;
    pushReqs(1);
    stepCycle();
    stepCycle();
    repeat (TIMEOUT - 1) stepCycle();
    compare("nack_not_early", tp_resp_valid, 0);
    stepCycle();
    compare("nack_valid", tp_resp_valid, 1);
    compare("nack_bits", {tp_resp_bits_ack, tp_resp_bits_data}, {1'b0, 32'hFFFF_FFFF});
    compare("nack_err_set", timeout_err, 1);
    repeat (3) stepCycle();
    tgt_en = 1; tgt_delay = 0;
    stepCycle();
    compare("late_dropped_outstanding", outstanding, 0);
    sink_en = 1;
    pushReqs(1);
    clr_err = 1'b1;
    stepCycle();
    clr_err = 1'b0;
    drain(100);
    compare("err_cleared", timeout_err, 0);

    // Expiry collision: a real answer on the expiry cycle suppresses the NACK
    tgt_en = 0; sink_en = 0;
    pushReqs(1);
    stepCycle();
    stepCycle();
    repeat (TIMEOUT - 1) stepCycle();
    tgt_en = 1; tgt_delay = 0;
    stepCycle();
    compare("collision_valid", tp_resp_valid, 1);
    compare("collision_bits", {tp_resp_bits_ack, tp_resp_bits_data},
            {io_resp_bits_ack, io_resp_bits_data});
    compare("collision_no_err", timeout_err, 0);
    sink_en = 1;
    drain(100);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
